// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the decoder pipeline:
//   mode_e      - decode mode encoding carried on the 2-bit mode input
//   FIFO_DEPTH  - number of entries in the output skid buffer
//   CNT_W       - width of the occupancy counter for that buffer
// ---------------------------------------------------------------------------
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_ONEHOT  = 2'b00,
    MODE_ONECOLD = 2'b01,
    MODE_THERMO  = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 2;

  // Occupancy value at which the buffer can take no further pushes.
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

endpackage

// File: rtl/decoder_skid.sv
// ---------------------------------------------------------------------------
// decoder_skid
// Two-entry FIFO holding decoded results until the consumer takes them.
// Push and pop may happen on the same edge; order is always preserved.
// Pushes into a full buffer and pops from an empty one are ignored.
//
// Ports:
//   clk    in   clock, all state on rising edge
//   rst    in   asynchronous active-low reset (clears entries and pointers)
//   push   in   write din at the tail
//   pop    in   drop the head entry
//   din    in   [W-1:0] payload written on push
//   dout   out  [W-1:0] head entry (all zero after reset)
//   count  out  [CNT_W-1:0] number of buffered entries
// ---------------------------------------------------------------------------
module decoder_skid
  import decoder_pkg::*;
#(
  parameter int W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem_r [FIFO_DEPTH];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against the current occupancy.
  always_comb begin
    push_ok_s = push && (count_r != FULL_CNT);
    pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
  end

  // Entry storage and write pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= 1'b0;
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
      wr_ptr_r        <= ~wr_ptr_r;
    end else begin
      wr_ptr_r <= wr_ptr_r;
    end
  end

  // Read pointer advances on every accepted pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_r <= 1'b0;
    end else if (pop_ok_s) begin
      rd_ptr_r <= ~rd_ptr_r;
    end else begin
      rd_ptr_r <= rd_ptr_r;
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/decoder_pipe.sv
// ---------------------------------------------------------------------------
// decoder_pipe
// Decodes a select code into a one-hot, one-cold or thermometer word at the
// moment a request is accepted, and queues the result (with an error flag)
// in a two-entry skid buffer that the consumer drains with a valid/ready
// handshake. Out-of-range selects and the reserved mode yield zero data
// with err set.
//
// Optional build macro:
//   DECODER_PIPE_ERR_CNT_EN  adds err_cnt, a saturating count of popped
//                            entries whose err flag was set.
//
// Parameters:
//   SEL_W  width of the select code
//   OUT_W  decoded word width (2 .. 2**SEL_W)
//
// Ports:
//   clk        in   clock, all state on rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  request accepted this edge when in_valid is also high
//   sel        in   [SEL_W-1:0] code to decode
//   mode       in   [1:0] decode mode (see decoder_pkg::mode_e)
//   out_valid  out  data_out/err hold a buffered result
//   out_ready  in   consumer takes the head result
//   data_out   out  [OUT_W-1:0] decoded word at the head
//   err        out  head result was out of range or used the reserved mode
//   err_cnt    out  [15:0] (macro only) saturating popped-error count
// ---------------------------------------------------------------------------
module decoder_pipe
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             err
`ifdef DECODER_PIPE_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);

  localparam int PAY_W = OUT_W + 1;

  logic             en_r;
  mode_e            mode_s;
  logic [OUT_W-1:0] dec_data_s;
  logic             dec_err_s;
  logic             push_s;
  logic             pop_s;
  logic [CNT_W-1:0] count_s;
  logic [PAY_W-1:0] head_s;

  // Enable goes high on the first edge after reset release, so no request
  // can be accepted on that first edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_r <= 1'b0;
    end else begin
      en_r <= 1'b1;
    end
  end

  // Combinational decode of the request as offered; captured only on accept.
  always_comb begin
    mode_s     = mode_e'(mode);
    dec_data_s = {OUT_W{1'b0}};
    dec_err_s  = 1'b0;
    if (32'(sel) >= 32'(OUT_W)) begin
      dec_err_s = 1'b1;
    end else begin
      case (mode_s)
        MODE_ONEHOT: begin
          for (int i = 0; i < OUT_W; i++) begin
            dec_data_s[i] = (SEL_W'(i) == sel);
          end
        end
        MODE_ONECOLD: begin
          for (int i = 0; i < OUT_W; i++) begin
            dec_data_s[i] = (SEL_W'(i) != sel);
          end
        end
        MODE_THERMO: begin
          for (int i = 0; i < OUT_W; i++) begin
            dec_data_s[i] = (SEL_W'(i) <= sel);
          end
        end
        MODE_RSVD: begin
          dec_err_s = 1'b1;
        end
        default: begin
          dec_err_s = 1'b1;
        end
      endcase
    end
  end

  // Handshakes: in_ready depends only on registered state, never on in_valid.
  always_comb begin
    in_ready  = en_r && (count_s != FULL_CNT);
    out_valid = (count_s != {CNT_W{1'b0}});
    push_s    = in_valid && in_ready;
    pop_s     = out_valid && out_ready;
  end

  decoder_skid #(
    .W (PAY_W)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .din   ({dec_err_s, dec_data_s}),
    .dout  (head_s),
    .count (count_s)
  );

  // Head entry comes straight from buffer flops, so it is stable while stalled.
  assign err      = head_s[PAY_W-1];
  assign data_out = head_s[OUT_W-1:0];

`ifdef DECODER_PIPE_ERR_CNT_EN
  logic [15:0] err_cnt_r;

  // Count popped error entries, holding at the maximum value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt_r <= 16'd0;
    end else if (pop_s && err && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'd1;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// ---------------------------------------------------------------------------
// tb_decoder_pipe
// Drives two decoder_pipe instances (OUT_W=8 and OUT_W=6) from the same
// stimulus and compares both against a queue-based reference model that
// decodes with plain integer arithmetic.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_decoder_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] sel;
  logic [1:0] mode;
  logic       out_ready;

  logic       in_ready8, out_valid8, err8;
  logic [7:0] data_out8;
  logic       in_ready6, out_valid6, err6;
  logic [5:0] data_out6;
`ifdef DECODER_PIPE_ERR_CNT_EN
  logic [15:0] err_cnt8, err_cnt6;
`endif

  int checks;
  int errors;

  // reference model state
  int   q_sel[$];
  int   q_mode[$];
  logic en_m;
  int   errs8_m;
  int   errs6_m;
  int   pops;

  decoder_pipe #(.SEL_W(3), .OUT_W(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .sel       (sel),
    .mode      (mode),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .data_out  (data_out8),
    .err       (err8)
`ifdef DECODER_PIPE_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt8)
`endif
  );

  decoder_pipe #(.SEL_W(3), .OUT_W(6)) dut6 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready6),
    .sel       (sel),
    .mode      (mode),
    .out_valid (out_valid6),
    .out_ready (out_ready),
    .data_out  (data_out6),
    .err       (err6)
`ifdef DECODER_PIPE_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt6)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {err, data[7:0]} for a w-bit decoder.
  function automatic logic [8:0] ref_dec(input int s, input int m, input int w);
    int d;
    if (s >= w || m == 3) return {1'b1, 8'h00};
    case (m)
      0:       d = 1 << s;
      1:       d = ((1 << w) - 1) & ~(1 << s);
      default: d = (1 << (s + 1)) - 1;
    endcase
    return {1'b0, 8'(d)};
  endfunction

  // One clock cycle: drive inputs at the falling edge, check outputs,
  // then advance the model across the rising edge.
  task automatic step(input logic v, input int s, input int m, input logic r);
    logic       exp_rdy;
    logic       acc;
    logic       pp;
    logic [8:0] e8;
    logic [8:0] e6;
    in_valid  = v;
    sel       = 3'(s);
    mode      = 2'(m);
    out_ready = r;
    e8 = 9'd0;
    e6 = 9'd0;
    exp_rdy = en_m && (q_sel.size() < 2);
    chk("in_ready8", 32'(in_ready8), 32'(exp_rdy));
    chk("in_ready6", 32'(in_ready6), 32'(exp_rdy));
    chk("out_valid8", 32'(out_valid8), 32'(q_sel.size() != 0));
    chk("out_valid6", 32'(out_valid6), 32'(q_sel.size() != 0));
    if (q_sel.size() != 0) begin
      e8 = ref_dec(q_sel[0], q_mode[0], 8);
      e6 = ref_dec(q_sel[0], q_mode[0], 6);
      chk("data_out8", 32'(data_out8), 32'(e8[7:0]));
      chk("err8", 32'(err8), 32'(e8[8]));
      chk("data_out6", 32'(data_out6), 32'(e6[5:0]));
      chk("err6", 32'(err6), 32'(e6[8]));
    end
`ifdef DECODER_PIPE_ERR_CNT_EN
    chk("err_cnt8", 32'(err_cnt8), 32'(errs8_m));
    chk("err_cnt6", 32'(err_cnt6), 32'(errs6_m));
`endif
    acc = v && exp_rdy;
    pp  = r && (q_sel.size() != 0);
    @(posedge clk);
    if (pp) begin
      if (e8[8] && errs8_m < 65535) errs8_m++;
      if (e6[8] && errs6_m < 65535) errs6_m++;
      pops++;
      void'(q_sel.pop_front());
      void'(q_mode.pop_front());
    end
    if (acc) begin
      q_sel.push_back(s);
      q_mode.push_back(m);
    end
    en_m = 1'b1;
    @(negedge clk);
  endtask

  // Assert reset (outputs must clear at once), hold, release at a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("rst_out_valid8", 32'(out_valid8), 32'd0);
    chk("rst_out_valid6", 32'(out_valid6), 32'd0);
    chk("rst_in_ready8", 32'(in_ready8), 32'd0);
    chk("rst_data_out8", 32'(data_out8), 32'd0);
    chk("rst_err8", 32'(err8), 32'd0);
    chk("rst_data_out6", 32'(data_out6), 32'd0);
`ifdef DECODER_PIPE_ERR_CNT_EN
    chk("rst_err_cnt8", 32'(err_cnt8), 32'd0);
    chk("rst_err_cnt6", 32'(err_cnt6), 32'd0);
`endif
    q_sel.delete();
    q_mode.delete();
    en_m    = 1'b0;
    errs8_m = 0;
    errs6_m = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int p0;
    checks    = 0;
    errors    = 0;
    pops      = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    sel       = 3'd0;
    mode      = 2'd0;
    out_ready = 1'b0;
    en_m      = 1'b0;
    errs8_m   = 0;
    errs6_m   = 0;
    @(negedge clk);
    do_reset();

    // first request after release: refused on the first edge, taken on the next
    step(1'b1, 3, 0, 1'b1);
    step(1'b1, 3, 0, 1'b1);
    chk("first_data", 32'(data_out8), 32'h08);
    chk("first_valid", 32'(out_valid8), 32'd1);
    step(1'b0, 0, 0, 1'b1);

    // one-cold, thermometer, reserved
    step(1'b1, 0, 1, 1'b1);
    step(1'b1, 5, 2, 1'b1);
    step(1'b1, 2, 3, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);

    // out-of-range for the 6-bit instance (and 7 in range for 8-bit)
    step(1'b1, 7, 0, 1'b1);
    step(1'b1, 6, 2, 1'b1);
    step(1'b1, 7, 1, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);

    // backpressure: third request refused until the consumer drains
    step(1'b1, 1, 0, 1'b0);
    step(1'b1, 2, 1, 1'b0);
    step(1'b1, 4, 2, 1'b0);
    step(1'b1, 4, 2, 1'b0);
    chk("bp_in_ready", 32'(in_ready8), 32'd0);
    step(1'b1, 4, 2, 1'b1);
    step(1'b1, 4, 2, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    step(1'b0, 0, 0, 1'b1);

    // back-to-back throughput
    p0 = pops;
    for (int i = 0; i < 8; i++) step(1'b1, i, 2, 1'b1);
    step(1'b0, 0, 0, 1'b1);
    chk("b2b_pops", 32'(pops - p0), 32'd8);
    step(1'b0, 0, 0, 1'b1);

    // reset with two entries buffered
    step(1'b1, 1, 0, 1'b0);
    step(1'b1, 3, 3, 1'b0);
    chk("pre_rst_valid", 32'(out_valid8), 32'd1);
    do_reset();
    step(1'b1, 2, 0, 1'b1);
    step(1'b1, 2, 0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
DECODER_PIPE -- requirements
Module: decoder_pipe

Interface
REQ-001 SHALL have parameter SEL_W, default 3, meaning the width of the select code.
REQ-002 SHALL have parameter OUT_W, default 8, meaning the decoded output width; legal range is 2..2**SEL_W.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the request is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the request.
REQ-007 SHALL have port sel, input, SEL_W bits: the code to decode.
REQ-008 SHALL have port mode, input, 2 bits: the decode mode, captured with sel.
REQ-009 SHALL have port out_valid, output, 1 bit: data_out is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream accepts data_out.
REQ-011 SHALL have port data_out, output, OUT_W bits: the decoded word.
REQ-012 SHALL have port err, output, 1 bit: the entry at data_out was out-of-range or used the reserved mode.

Function
REQ-013 SHALL have an internal enable flop: 0 in reset, 1 from the first clk edge after rst deasserts; while it is 0, in_ready SHALL be 0.
REQ-014 SHALL accept a request on an edge where in_valid && in_ready.
REQ-015 SHALL decode each request at acceptance into a 2-entry FIFO (skid buffer); latency is 1 cycle from the accept edge to out_valid.
REQ-016 SHALL drive in_ready = enable && (fifo count < 2); in_ready SHALL not depend combinationally on in_valid.
REQ-017 SHALL, for mode 00 (one-hot), set data_out[sel]=1 and all other bits 0.
REQ-018 SHALL, for mode 01 (one-cold), set data_out[sel]=0 and all other bits 1.
REQ-019 SHALL, for mode 10 (thermometer), set data_out[sel:0]=1 and all other bits 0.
REQ-020 SHALL, for mode 11 (reserved), output all zero with err=1.
REQ-021 SHALL, if sel >= OUT_W, output all zero with err=1 regardless of mode.
REQ-022 SHALL pop the head entry on an edge where out_valid && out_ready; a simultaneous push and pop keeps the count unchanged and preserves order.
REQ-023 SHALL hold data_out and err stable while out_valid=1 and out_ready=0.
REQ-024 SHALL drive out_valid = (count != 0); with out_ready held at 1, the block SHALL sustain 1 result per cycle.

Reset
REQ-025 SHALL, when rst is asserted at any time (including mid-transfer), asynchronously clear enable, the FIFO count, the pointers, out_valid, data_out and err to 0, and discard buffered entries.
REQ-026 SHALL, after release, return in_ready to 1 exactly one edge later.

Configuration
REQ-027 SHALL, when DECODER_PIPE_ERR_CNT_EN is defined, add output err_cnt [15:0]: it increments when an entry with err=1 is popped, saturates at 16'hFFFF, and resets to 0.
REQ-028 SHALL, when DECODER_PIPE_ERR_CNT_EN is undefined, have no err_cnt port and no counter logic.

Structure
REQ-029 SHALL place the mode encoding (typedef enum MODE_ONEHOT, MODE_ONECOLD, MODE_THERMO, MODE_RSVD) and the FIFO depth constant 2 in the shared package decoder_pkg.
REQ-030 SHALL implement the 2-entry buffer as sub-module decoder_skid, parameterised on the payload width OUT_W+1.

Verification
REQ-031 SHALL verify: reset release, then in_valid=1 with sel=3, mode=00 -> in_ready=0 on the first edge; accepted next edge; data_out=8'h08 and out_valid=1 one cycle later.
REQ-032 SHALL verify: mode=01 with sel=0 -> data_out=8'hFE; mode=10 with sel=5 -> data_out=8'h3F; mode=11 -> data_out=8'h00 and err=1.
REQ-033 SHALL verify: OUT_W=6 with sel=7 -> data_out=6'h00 and err=1.
REQ-034 SHALL verify: out_ready=0 and 3 requests offered -> 2 accepted, in_ready=0, head stable; out_ready=1 -> outputs in order, third request accepted.
REQ-035 SHALL verify: back-to-back sel=0..7 with out_ready=1 -> 8 results on 8 consecutive cycles.
REQ-036 SHALL verify: rst asserted with 2 entries buffered -> out_valid=0 immediately; err_cnt=0 (when DECODER_PIPE_ERR_CNT_EN is defined).
